// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data-memory controller: word RAM, LED register, sized loads/stores.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h1000,
  parameter logic [31:0] LED_ADDR    = 32'h2000,
  parameter int unsigned LED_WIDTH   = 8,
  parameter string       INIT_FILE   = "verilog/data.hex"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic [LED_WIDTH-1:0] led,
  output logic                 clk_stall,
  output logic                 err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, READ, WRITE} state_t;

  state_t               state_q, state_d;
  logic                 stall_q, stall_d;
  logic [31:0]          addr_buf_q, addr_buf_d;
  logic [31:0]          wdata_buf_q, wdata_buf_d;
  logic [3:0]           sign_mask_buf_q, sign_mask_buf_d;
  logic                 is_write_q, is_write_d;
  logic [31:0]          word_buf_q, word_buf_d;
  logic [31:0]          read_data_q, read_data_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 err_q, err_d;

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_ram;
  logic          is_led;
  logic [AW-1:0] word_idx;
  logic          is_byte;
  logic          is_half;
  logic [1:0]    lane;
  logic          misalign;
  logic [3:0]    size_mask;
  logic [3:0]    lane_en;
  logic [31:0]   store_word;
  logic [31:0]   merged_word;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;
  logic [31:0]   led_word;
  logic [31:0]   load_value;
  logic [31:0]   ram_rdata;
  logic          ram_we;

  // Subtracting the base first lets one unsigned compare reject addresses on both sides of the window.
  always_comb begin
    offset   = addr_buf_q - ADDR_BASE;
    in_ram   = offset < RAM_BYTES;
    is_led   = addr_buf_q == LED_ADDR;
    word_idx = offset[AW+1:2];
    is_byte  = sign_mask_buf_q[2:0] == 3'b001;
    is_half  = sign_mask_buf_q[2:0] == 3'b011;
    if (is_byte) begin
      lane       = addr_buf_q[1:0];
      size_mask  = 4'b0001;
      store_word = {4{wdata_buf_q[7:0]}};
    end else if (is_half) begin
      lane       = {addr_buf_q[1], 1'b0};
      size_mask  = 4'b0011;
      store_word = {2{wdata_buf_q[15:0]}};
    end else begin
      lane       = 2'b00;
      size_mask  = 4'b1111;
      store_word = wdata_buf_q;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (is_half & addr_buf_q[0]) | (~is_byte & ~is_half & (addr_buf_q[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    lane_en = size_mask << lane;
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = lane_en[i] ? store_word[8*i +: 8] : word_buf_q[8*i +: 8];
    end
  end

  always_comb begin
    shifted = word_buf_q >> {lane, 3'b000};
    if (is_byte) begin
      load_ext = {{24{sign_mask_buf_q[3] & shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_ext = {{16{sign_mask_buf_q[3] & shifted[15]}}, shifted[15:0]};
    end else begin
      load_ext = shifted;
    end
    led_word                  = '0;
    led_word[LED_WIDTH-1:0]   = led_q;
    if (misalign) begin
      load_value = '0;
    end else if (in_ram) begin
      load_value = load_ext;
    end else if (is_led) begin
      load_value = led_word;
    end else begin
      load_value = '0;
    end
  end

  assign ram_rdata = ram[word_idx];
  assign ram_we    = (state_q == WRITE) & in_ram & ~misalign & ~reset;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[word_idx] <= merged_word;
    end
  end

  always_comb begin
    state_d         = state_q;
    stall_d         = stall_q;
    addr_buf_d      = addr_buf_q;
    wdata_buf_d     = wdata_buf_q;
    sign_mask_buf_d = sign_mask_buf_q;
    is_write_d      = is_write_q;
    word_buf_d      = word_buf_q;
    read_data_d     = read_data_q;
    led_d           = led_q;
    err_d           = 1'b0;
    case (state_q)
      IDLE: begin
        addr_buf_d      = addr;
        wdata_buf_d     = write_data;
        sign_mask_buf_d = sign_mask;
        is_write_d      = memwrite;
        if (memread | memwrite) begin
          state_d = FETCH;
          stall_d = 1'b1;
        end
      end
      FETCH: begin
        word_buf_d = ram_rdata;
        state_d    = is_write_q ? WRITE : READ;
      end
      READ: begin
        read_data_d = load_value;
        err_d       = misalign;
        stall_d     = 1'b0;
        state_d     = IDLE;
      end
      WRITE: begin
        if (is_led & ~misalign) begin
          led_d = wdata_buf_q[LED_WIDTH-1:0];
        end
        err_d   = misalign;
        stall_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      stall_q         <= 1'b0;
      addr_buf_q      <= '0;
      wdata_buf_q     <= '0;
      sign_mask_buf_q <= '0;
      is_write_q      <= 1'b0;
      word_buf_q      <= '0;
      read_data_q     <= '0;
      led_q           <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_q         <= stall_d;
      addr_buf_q      <= addr_buf_d;
      wdata_buf_q     <= wdata_buf_d;
      sign_mask_buf_q <= sign_mask_buf_d;
      is_write_q      <= is_write_d;
      word_buf_q      <= word_buf_d;
      read_data_q     <= read_data_d;
      led_q           <= led_d;
      err_q           <= err_d;
    end
  end

  assign read_data = read_data_q;
  assign led       = led_q;
  assign clk_stall = stall_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed and randomized bench for dmem_ctrl against a byte-array model.
module tb_dmem_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000;
  localparam logic [31:0] LEDA  = 32'h2000;
  localparam int          LW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr;
  logic [31:0]   write_data;
  logic          memwrite;
  logic          memread;
  logic [3:0]    sign_mask;
  logic [31:0]   read_data;
  logic [LW-1:0] led;
  logic          clk_stall;
  logic          err;

  logic [7:0]  mem_b [4*DEPTH];
  logic [7:0]  led_m;
  logic [31:0] last_rd;
  int checks = 0;
  int errors = 0;

  dmem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_BASE  (BASE),
    .LED_ADDR   (LEDA),
    .LED_WIDTH  (LW),
    .INIT_FILE  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .write_data(write_data),
    .memwrite  (memwrite),
    .memread   (memread),
    .sign_mask (sign_mask),
    .read_data (read_data),
    .led       (led),
    .clk_stall (clk_stall),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] sm);
    case (sm[2:0])
      3'b001:  return 1;
      3'b011:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [3:0] sm);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (a % size_of(sm)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4*DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] sm);
    int n;
    int off;
    logic [63:0] v;
    n = size_of(sm);
    if (misaligned(a, sm)) return 32'h0;
    if (a == LEDA) return {24'h0, led_m};
    if (!in_ram(a)) return 32'h0;
    off = int'(a - BASE);
    off = off - (off % n);
    v = '0;
    for (int i = 0; i < n; i++) v |= 64'(mem_b[off+i]) << (8*i);
    if (sm[3] && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
    int n;
    int off;
    n = size_of(sm);
    if (misaligned(a, sm)) return;
    if (a == LEDA) begin
      led_m = wd[7:0];
    end else if (in_ram(a)) begin
      off = int'(a - BASE);
      off = off - (off % n);
      for (int i = 0; i < n; i++) mem_b[off+i] = 8'(wd >> (8*i));
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sm, input string tag);
    bit exp_err;
    exp_err = misaligned(a, sm);
    if (wr) model_store(a, wd, sm);
    else last_rd = model_load(a, sm);
    addr = a; write_data = wd; sign_mask = sm; memread = rd; memwrite = wr;
    @(posedge clk); #1;
    check({tag, " stall_n"}, {31'b0, clk_stall}, 32'd1);
    check({tag, " err_idle"}, {31'b0, err}, 32'd0);
    addr = $urandom; write_data = $urandom; sign_mask = 4'($urandom); memwrite = 1'b1; memread = 1'($urandom);
    @(posedge clk); #1;
    check({tag, " stall_n1"}, {31'b0, clk_stall}, 32'd1);
    @(posedge clk); #1;
    check({tag, " stall_n2"}, {31'b0, clk_stall}, 32'd0);
    check({tag, " read_data"}, read_data, last_rd);
    check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, " led"}, {24'b0, led}, {24'b0, led_m});
    memread = 1'b0; memwrite = 1'b0;
  endtask

  logic [3:0] sm_tab [8];

  initial begin
    sm_tab[0] = 4'b0001; sm_tab[1] = 4'b1001; sm_tab[2] = 4'b0011; sm_tab[3] = 4'b1011;
    sm_tab[4] = 4'b0111; sm_tab[5] = 4'b1111; sm_tab[6] = 4'b0000; sm_tab[7] = 4'b1101;
    reset = 1'b1; addr = '0; write_data = '0; memwrite = 1'b0; memread = 1'b0; sign_mask = '0;
    led_m = '0; last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall", {31'b0, clk_stall}, 32'd0);
    check("rst read_data", read_data, 32'd0);
    check("rst led", {24'b0, led}, 32'd0);
    check("rst err", {31'b0, err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, BASE + 32'(4*i), $urandom, 4'b0111, "init");

    access(1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'b0111, "w1004");
    access(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0111, "r1004");
    check("tp word", read_data, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h1004, 32'h11223344, 4'b0111, "w1004b");
    access(1'b0, 1'b1, 32'h1007, 32'h00000080, 4'b0001, "sb1007");
    access(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0111, "lw1004");
    check("tp byte merge", read_data, 32'h80223344);
    access(1'b1, 1'b0, 32'h1007, 32'h0, 4'b1001, "lb1007");
    check("tp lb signed", read_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h1007, 32'h0, 4'b0001, "lbu1007");
    check("tp lbu", read_data, 32'h00000080);

    access(1'b0, 1'b1, 32'h1008, 32'h13572468, 4'b0111, "w1008");
    access(1'b0, 1'b1, 32'h100A, 32'h0000A5A5, 4'b0011, "sh100a");
    access(1'b1, 1'b0, 32'h100A, 32'h0, 4'b1011, "lh100a");
    check("tp lh signed", read_data, 32'hFFFFA5A5);
    access(1'b1, 1'b0, 32'h1008, 32'h0, 4'b0111, "lw1008");
    check("tp half lanes", read_data, 32'hA5A52468);

    access(1'b0, 1'b1, LEDA, 32'h0000005A, 4'b0111, "wled");
    check("tp led", {24'b0, led}, 32'h5A);
    access(1'b1, 1'b0, LEDA, 32'h0, 4'b0111, "rled");
    check("tp led read", read_data, 32'h0000005A);
    access(1'b0, 1'b1, 32'h3000, 32'hCAFEF00D, 4'b0111, "w3000");
    access(1'b1, 1'b0, 32'h3000, 32'h0, 4'b0111, "r3000");
    check("tp unmapped read", read_data, 32'h0);

    access(1'b0, 1'b1, 32'h1000, 32'h0BADF00D, 4'b0111, "w1000");
    access(1'b1, 1'b0, 32'h1002, 32'h0, 4'b0111, "lw1002");
`ifdef DMEM_MISALIGN_TRAP_EN
    check("tp misalign read", read_data, 32'h0);
`else
    check("tp misalign read", read_data, 32'h0BADF00D);
`endif

    addr = 32'h1000; write_data = 32'h12345678; sign_mask = 4'b0111; memwrite = 1'b1; memread = 1'b0;
    @(posedge clk); #1;
    memwrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst mid stall", {31'b0, clk_stall}, 32'd0);
    check("rst mid read_data", read_data, 32'd0);
    check("rst mid led", {24'b0, led}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    led_m = '0; last_rd = '0;
    access(1'b1, 1'b0, 32'h1000, 32'h0, 4'b0111, "r1000 post rst");
    check("tp reset keeps ram", read_data, 32'h0BADF00D);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      int kind;
      int op;
      kind = $urandom_range(0, 9);
      if (kind <= 6) a = BASE + 32'($urandom_range(0, 4*DEPTH-1));
      else if (kind == 7) a = LEDA;
      else if (kind == 8) a = 32'h3000 + 32'($urandom_range(0, 15));
      else a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'(4*DEPTH);
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, $urandom, sm_tab[$urandom_range(0, 7)], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
